wb_rr_arbiter: RTL and testbench

Parametrised N-master to 1-slave Wishbone classic arbiter with round-robin fairness. It sits between the DSP core, added bus masters (DMA, debug) and the single shared wb_sdram_ctrl. It lets the SoC grow beyond one master without touching the SDRAM controller. A grant is held for the master's whole cyc window, so bursts and read-modify-write sequences are atomic.

---
 rtl/wb_arb_pkg.sv | 39 +++
 rtl/wb_rr_arbiter_rr_pick.sv | 19 +
 rtl/wb_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types, default widths and the round-robin pick function for wb_rr_arbiter.
package wb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_MASTERS  = 8;
  localparam int unsigned PTR_W        = 3;
  localparam int unsigned DEF_MASTERS  = 2;
  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_TIMEOUT  = 64;

  // One-hot pick of the first requester at or after last+1, wrapping modulo n.
  function automatic logic [MAX_MASTERS-1:0] rr_pick_f(
    input logic [MAX_MASTERS-1:0] req,
    input logic [PTR_W-1:0]       last,
    input int unsigned            n
  );
    logic [MAX_MASTERS-1:0] gnt;
    logic                   found;
    int unsigned            idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_MASTERS; i++) begin
      if (i <= n) begin
        idx = (32'(last) + i) % n;
        if (!found && req[idx[PTR_W-1:0]]) begin
          gnt[idx[PTR_W-1:0]] = 1'b1;
          found               = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin priority selector: request vector + last owner -> one-hot grant.
module rr_pick
  import wb_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_last,
  output logic [N-1:0]     o_gnt_c
);

  logic [MAX_MASTERS-1:0] w_req;
  logic [MAX_MASTERS-1:0] w_gnt;

  assign w_req   = MAX_MASTERS'(i_req);
  assign w_gnt   = rr_pick_f(w_req, i_last, N);
  assign o_gnt_c = N'(w_gnt);

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone classic round-robin arbiter; grant held for the whole cyc window.
// Optional slave-ack watchdog enabled with `define WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned  NUM_MASTERS    = DEF_MASTERS,
  parameter int unsigned  ADDR_W         = DEF_ADDR_W,
  parameter int unsigned  DATA_W         = DEF_DATA_W,
  parameter int unsigned  TIMEOUT_CYCLES = DEF_TIMEOUT,
  localparam int unsigned SEL_W          = DATA_W / 8
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_dat_i,
  input  logic [NUM_MASTERS*SEL_W-1:0]  m_sel_i,
  output logic [DATA_W-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic                          s_we_o,
  output logic [ADDR_W-1:0]             s_adr_o,
  output logic [DATA_W-1:0]             s_dat_o,
  output logic [SEL_W-1:0]              s_sel_o,
  input  logic [DATA_W-1:0]             s_dat_i,
  input  logic                          s_ack_i,
  output logic [NUM_MASTERS-1:0]        grant_o
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("wb_rr_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  arb_state_e              r_state;
  logic [NUM_MASTERS-1:0]  r_grant;
  logic [PTR_W-1:0]        r_last;
  logic [NUM_MASTERS-1:0]  w_pick;
  logic [PTR_W-1:0]        w_pick_idx;
  logic [NUM_MASTERS-1:0]  w_live;
  logic                    w_owner_cyc;
  logic                    w_abort;
  logic                    w_we;
  logic [ADDR_W-1:0]       w_adr;
  logic [DATA_W-1:0]       w_dat;
  logic [SEL_W-1:0]        w_sel;

  rr_pick #(.N(NUM_MASTERS)) u_pick (
    .i_req   (m_cyc_i),
    .i_last  (r_last),
    .o_gnt_c (w_pick)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (w_pick[k]) w_pick_idx = PTR_W'(k);
    end
  end

  // AND-OR mux of the owner's request lines; all zero while nobody holds the grant.
  always_comb begin
    w_we  = 1'b0;
    w_adr = '0;
    w_dat = '0;
    w_sel = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (r_grant[k]) begin
        w_we  = m_we_i[k];
        w_adr = m_adr_i[k*ADDR_W +: ADDR_W];
        w_dat = m_dat_i[k*DATA_W +: DATA_W];
        w_sel = m_sel_i[k*SEL_W +: SEL_W];
      end
    end
  end

  assign w_live      = r_grant & {NUM_MASTERS{~w_abort}};
  assign w_owner_cyc = |(r_grant & m_cyc_i);

  assign s_cyc_o = |(w_live & m_cyc_i);
  assign s_stb_o = |(w_live & m_stb_i);
  assign s_we_o  = w_we & ~w_abort;
  assign s_adr_o = w_adr;
  assign s_dat_o = w_dat;
  assign s_sel_o = w_sel;
  assign m_ack_o = w_live & {NUM_MASTERS{s_ack_i}};
  assign m_dat_o = s_dat_i;
  assign grant_o = r_grant;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= PTR_W'(NUM_MASTERS - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (|m_cyc_i) begin
            r_grant <= w_pick;
            r_last  <= w_pick_idx;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (!w_owner_cyc) begin
            r_grant <= '0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_grant <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_abort;
  logic             w_timeout;

  // Fires on the last stalled strobe cycle; an ack in that same cycle wins.
  assign w_timeout = (r_state == BUSY) && !r_abort && s_stb_o && !s_ack_i &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cnt   <= '0;
      r_abort <= 1'b0;
    end else if (r_state == IDLE) begin
      r_cnt   <= '0;
      r_abort <= 1'b0;
    end else if (s_ack_i && !r_abort) begin
      r_cnt   <= '0;
    end else if (w_timeout) begin
      r_cnt   <= '0;
      r_abort <= 1'b1;
    end else if (s_stb_o) begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign w_abort = r_abort;
  assign m_err_o = r_grant & {NUM_MASTERS{w_timeout}};
`else
  assign w_abort = 1'b0;
  assign m_err_o = '0;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter: 4 masters, modelled slave, expected beats queued in service order.
module tb_wb_rr_arbiter;

  localparam int NM = 4;

  typedef struct {
    int          owner;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rdata;
  } exp_t;

  logic            clk;
  logic            wb_rst_i;
  logic [NM-1:0]   m_cyc, m_stb, m_we;
  logic [NM*32-1:0] m_adr, m_dat;
  logic [NM*4-1:0] m_sel;
  logic [31:0]     m_dat_o;
  logic [NM-1:0]   m_ack_o, m_err_o, grant_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [31:0]     s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]      s_sel_o;
  logic            s_ack_i, sl_ack, stray_ack;

  logic            sl_mute;
  int              sl_lat;
  int              n_checks = 0;
  int              n_pass   = 0;
  exp_t            sb[$];

  assign s_ack_i = sl_ack | stray_ack;

  wb_rr_arbiter #(
    .NUM_MASTERS(NM), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [3:0] sel_of(input int k);
    return 4'(4'hF >> k);
  endfunction

  task automatic push_exp(input int k, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [31:0] rdata);
    exp_t e;
    e.owner = k; e.we = we; e.adr = adr; e.dat = dat; e.sel = sel_of(k); e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Slave: acks after sl_lat idle-request negedges, checks each beat against the queue head.
  initial begin
    exp_t        e;
    int          wcnt;
    logic [3:0]  oh;
    sl_ack  = 1'b0;
    s_dat_i = '0;
    wcnt    = 0;
    forever begin
      @(negedge clk);
      if (wb_rst_i || sl_ack) begin
        sl_ack = 1'b0;
        wcnt   = 0;
      end else if (s_cyc_o && s_stb_o && !sl_mute) begin
        if (wcnt >= sl_lat) begin
          check("sb_pending", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            e  = sb.pop_front();
            oh = 4'(1 << e.owner);
            check("grant", 64'(grant_o), 64'(oh));
            check("s_adr", 64'(s_adr_o), 64'(e.adr));
            check("s_we", 64'(s_we_o), 64'(e.we));
            check("s_sel", 64'(s_sel_o), 64'(e.sel));
            if (e.we) check("s_dat", 64'(s_dat_o), 64'(e.dat));
            s_dat_i = e.rdata;
            sl_ack  = 1'b1;
            #1;
            check("m_ack", 64'(m_ack_o), 64'(oh));
            check("m_dat", 64'(m_dat_o), 64'(e.rdata));
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic mtxn(input int k, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input int beats);
    bit got;
    @(posedge clk); #1;
    m_cyc[k] = 1'b1;
    m_stb[k] = 1'b1;
    m_we[k]  = we;
    m_sel[k*4 +: 4] = sel_of(k);
    for (int b = 0; b < beats; b++) begin
      m_adr[k*32 +: 32] = adr + 32'(4 * b);
      m_dat[k*32 +: 32] = dat + 32'(b);
      got = 1'b0;
      for (int t = 0; t < 300; t++) begin
        @(posedge clk); #1;
        if (m_ack_o[k] || m_err_o[k]) begin
          got = 1'b1;
          break;
        end
      end
      check($sformatf("ack_wait_m%0d", k), 64'(got), 64'd1);
    end
    m_cyc[k] = 1'b0;
    m_stb[k] = 1'b0;
    m_we[k]  = 1'b0;
  endtask

  task automatic fair_master(input int k);
    for (int r = 0; r < 2; r++)
      mtxn(k, 1'b1, 32'h1000 + 32'(k * 'h100) + 32'(r * 'h10), 32'hF000_0000 | 32'(k << 8) | 32'(r), 1);
  endtask

  initial begin
    wb_rst_i  = 1'b1;
    m_cyc     = '0; m_stb = '0; m_we = '0;
    m_adr     = '0; m_dat = '0; m_sel = '0;
    stray_ack = 1'b0;
    sl_mute   = 1'b0;
    sl_lat    = 3;
    repeat (2) @(negedge clk);
    check("rst_grant", 64'(grant_o), 64'd0);
    check("rst_cyc", 64'(s_cyc_o), 64'd0);
    check("rst_stb", 64'(s_stb_o), 64'd0);
    check("rst_we", 64'(s_we_o), 64'd0);
    check("rst_ack", 64'(m_ack_o), 64'd0);
    check("rst_err", 64'(m_err_o), 64'd0);
    wb_rst_i = 1'b0;

    // Single master read: one cycle of arbitration latency.
    push_exp(1, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF);
    fork
      mtxn(1, 1'b0, 32'h100, 32'h0, 1);
      begin
        @(posedge clk);
        @(negedge clk);
        check("lat_cyc0", 64'(s_cyc_o), 64'd0);
        @(negedge clk);
        check("lat_cyc1", 64'(s_cyc_o), 64'd1);
        check("lat_grant", 64'(grant_o), 64'h2);
      end
    join

    // Slave ack while idle must not reach any master.
    @(posedge clk); #1;
    stray_ack = 1'b1;
    @(negedge clk);
    check("idle_ack", 64'(m_ack_o), 64'd0);
    check("idle_grant", 64'(grant_o), 64'd0);
    stray_ack = 1'b0;

    // Contention: m0 then m1 with one dead cycle between tenures.
    sl_lat = 1;
    push_exp(0, 1'b1, 32'h200, 32'hA0A0_0000, 32'h0);
    push_exp(1, 1'b1, 32'h300, 32'hB1B1_0001, 32'h0);
    fork
      mtxn(0, 1'b1, 32'h200, 32'hA0A0_0000, 1);
      mtxn(1, 1'b1, 32'h300, 32'hB1B1_0001, 1);
      begin
        for (int t = 0; t < 100; t++) begin @(negedge clk); if (grant_o == 4'h1) break; end
        for (int t = 0; t < 100; t++) begin @(negedge clk); if (grant_o != 4'h1) break; end
        check("dead_grant", 64'(grant_o), 64'd0);
        check("dead_cyc", 64'(s_cyc_o), 64'd0);
        @(negedge clk);
        check("next_grant", 64'(grant_o), 64'h2);
      end
    join

    // Locked burst: m1 waits out all four m0 beats.
    for (int b = 0; b < 4; b++) push_exp(0, 1'b1, 32'h400 + 32'(4 * b), 32'h5500_0000 + 32'(b), 32'h0);
    push_exp(1, 1'b1, 32'h500, 32'h6600_0000, 32'h0);
    fork
      mtxn(0, 1'b1, 32'h400, 32'h5500_0000, 4);
      begin
        repeat (2) @(posedge clk);
        mtxn(1, 1'b1, 32'h500, 32'h6600_0000, 1);
      end
    join

    // Reset in the middle of a stalled m1 tenure.
    sl_mute = 1'b1;
    @(posedge clk); #1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[32 +: 32] = 32'h900;
    repeat (3) @(negedge clk);
    check("mid_grant", 64'(grant_o), 64'h2);
    check("mid_cyc", 64'(s_cyc_o), 64'd1);
    #2 wb_rst_i = 1'b1;
    stray_ack = 1'b1;
    #1;
    check("arst_grant", 64'(grant_o), 64'd0);
    check("arst_cyc", 64'(s_cyc_o), 64'd0);
    check("arst_stb", 64'(s_stb_o), 64'd0);
    check("arst_ack", 64'(m_ack_o), 64'd0);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    stray_ack = 1'b0;
    sl_mute = 1'b0;
    @(negedge clk);
    wb_rst_i = 1'b0;

    // Fairness after reset: all four contend, service order 0,1,2,3,0,1,2,3.
    sl_lat = 0;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NM; k++)
        push_exp(k, 1'b1, 32'h1000 + 32'(k * 'h100) + 32'(r * 'h10), 32'hF000_0000 | 32'(k << 8) | 32'(r), 32'h0);
    fork
      fair_master(0);
      fair_master(1);
      fair_master(2);
      fair_master(3);
    join

    // Slave that never acks: m2 stalls; m3 follows once m2 lets go.
    sl_mute = 1'b1;
    @(posedge clk); #1;
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_adr[64 +: 32] = 32'hA00;
    @(negedge clk);
    check("stall_lat", 64'(s_cyc_o), 64'd0);
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check($sformatf("to_err_c%0d", i), 64'(m_err_o), (i == 8) ? 64'h4 : 64'h0);
    end
    check("to_cyc_c8", 64'(s_cyc_o), 64'd1);
    @(negedge clk);
    check("to_cyc_after", 64'(s_cyc_o), 64'd0);
    check("to_err_after", 64'(m_err_o), 64'd0);
    check("to_grant_held", 64'(grant_o), 64'h4);
`else
    repeat (10) @(negedge clk);
    check("stall_err", 64'(m_err_o), 64'd0);
    check("stall_cyc", 64'(s_cyc_o), 64'd1);
    check("stall_grant", 64'(grant_o), 64'h4);
`endif
    @(posedge clk); #1;
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    sl_mute = 1'b0;
    sl_lat  = 1;
    push_exp(3, 1'b0, 32'h700, 32'h0, 32'h1234_5678);
    mtxn(3, 1'b0, 32'h700, 32'h0, 1);

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
